acc_bank: RTL

- Parametrised successor to the single 8-bit accumulator register: a bank of NUM_ACC accumulators of WIDTH bits.
- Each accumulator can be loaded or updated in place by an ALU op against data_in, and the bank keeps carry/zero/negative flags.
- Includes a multi-cycle shift-add multiply under a valid/ready handshake.
- Sits between the data bus and the CPU control unit. Keeps the CPU convention: capture happens on the falling edge of clk.

---
 rtl/acc_bank.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/acc_bank.sv
// acc_bank: bank of NUM_ACC accumulators, each WIDTH bits wide, with a shared
// ALU, carry/zero/negative flags and a multi-cycle shift-add multiplier.
// All state changes on the falling edge of clk, matching the CPU that
// drives this block. rst_n is asynchronous and active low.
module acc_bank #(
  parameter  int WIDTH   = 8,
  parameter  int NUM_ACC = 2,
  localparam int SEL_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [2:0]       op,
  input  logic [SEL_W-1:0] acc_sel,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [WIDTH-1:0] data_out,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             done
);

  // Step counter only needs to reach WIDTH-1.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  state_t               state_reg;
  state_t               state_next;
  logic                 mul_busy;

  logic [WIDTH-1:0]     acc_val [NUM_ACC];

  // One-hot decodes of the select fields; an out-of-range select matches
  // nothing, which turns the op into a NOP and the read into zero.
  logic [NUM_ACC-1:0]   sel_hit;
  logic [NUM_ACC-1:0]   rd_hit;
  logic                 sel_ok;
  logic                 accept;

  logic [WIDTH-1:0]     acc_cur;
  logic [WIDTH:0]       sum_ext;
  logic [WIDTH:0]       diff_ext;

  logic                 alu_wr;
  logic [WIDTH-1:0]     alu_data;
  logic                 alu_carry;
  logic                 mul_start;

  logic [2*WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic [2*WIDTH-1:0]   prod_reg;
  logic [2*WIDTH-1:0]   prod_step;
  logic [CNT_W-1:0]     cnt_reg;
  logic [NUM_ACC-1:0]   tgt_reg;
  logic                 mul_last;

  logic                 wr_en;
  logic [NUM_ACC-1:0]   wr_hit;
  logic [WIDTH-1:0]     wr_data;
  logic                 wr_carry;

  logic                 carry_reg, carry_next;
  logic                 zero_reg,  zero_next;
  logic                 neg_reg,   neg_next;
  logic                 done_reg,  done_next;

  // ---------------------------------------------------------------------
  // Select decoding
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_ACC; gi++) begin : gen_sel
    assign sel_hit[gi] = (acc_sel == SEL_W'(gi));
    assign rd_hit[gi]  = (rd_sel  == SEL_W'(gi));
  end

  assign sel_ok = |sel_hit;
  assign accept = op_valid && op_ready;

  // Operand fetch: current value of the accumulator addressed by acc_sel.
  always_comb begin
    acc_cur = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (sel_hit[i]) acc_cur = acc_val[i];
    end
  end

  // Read port: registered accumulator at rd_sel, zero when out of range.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (rd_hit[i]) data_out = acc_val[i];
    end
  end

  // ---------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------
  // Widened by one bit so the top bit is the carry (ADD) or borrow (SUB).
  assign sum_ext  = {1'b0, acc_cur} + {1'b0, data_in};
  assign diff_ext = {1'b0, acc_cur} - {1'b0, data_in};

  // Decode an accepted op into an accumulator write or a multiply start.
  always_comb begin
    alu_wr    = 1'b0;
    alu_data  = acc_cur;
    alu_carry = 1'b0;
    mul_start = 1'b0;
    if (accept && sel_ok) begin
      case (op)
        OP_NOP: begin
          alu_wr = 1'b0;
        end
        OP_LOAD: begin
          alu_wr   = 1'b1;
          alu_data = data_in;
        end
        OP_ADD: begin
          alu_wr    = 1'b1;
          alu_data  = sum_ext[WIDTH-1:0];
          alu_carry = sum_ext[WIDTH];
        end
        OP_SUB: begin
          alu_wr    = 1'b1;
          alu_data  = diff_ext[WIDTH-1:0];
          alu_carry = diff_ext[WIDTH];
        end
        OP_AND: begin
          alu_wr   = 1'b1;
          alu_data = acc_cur & data_in;
        end
        OP_OR: begin
          alu_wr   = 1'b1;
          alu_data = acc_cur | data_in;
        end
        OP_SHL: begin
          alu_wr    = 1'b1;
          alu_data  = {acc_cur[WIDTH-2:0], 1'b0};
          alu_carry = acc_cur[WIDTH-1];
        end
        OP_MUL: begin
          mul_start = 1'b1;
        end
        default: begin
          alu_wr = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Shift-add multiplier
  // ---------------------------------------------------------------------
  // The multiplicand is pre-shifted each step, so one add per cycle
  // accumulates the partial product for the current multiplier LSB.
  assign prod_step = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign mul_last  = mul_busy && (cnt_reg == CNT_W'(WIDTH - 1));

  // Multiplier operands, running product, step count and write-back target.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      prod_reg   <= '0;
      cnt_reg    <= '0;
      tgt_reg    <= '0;
    end else if (mul_start) begin
      mcand_reg  <= {{WIDTH{1'b0}}, acc_cur};
      mplier_reg <= data_in;
      prod_reg   <= '0;
      cnt_reg    <= '0;
      tgt_reg    <= sel_hit;
    end else if (mul_busy) begin
      prod_reg   <= prod_step;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state: leave IDLE on an accepted MUL, return after the last step.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (mul_start) state_next = ST_MUL;
      ST_MUL:  if (mul_last)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs: ready only in IDLE, multiplier steps only in MUL.
  always_comb begin
    op_ready = 1'b0;
    mul_busy = 1'b0;
    case (state_reg)
      ST_IDLE: op_ready = 1'b1;
      ST_MUL:  mul_busy = 1'b1;
      default: op_ready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Accumulator write port and flags
  // ---------------------------------------------------------------------
  // Single write port: ALU writes happen only in IDLE and multiply
  // write-back only in MUL, so the two sources never collide.
  always_comb begin
    wr_en    = 1'b0;
    wr_hit   = '0;
    wr_data  = alu_data;
    wr_carry = alu_carry;
    if (mul_last) begin
      wr_en    = 1'b1;
      wr_hit   = tgt_reg;
      wr_data  = prod_step[WIDTH-1:0];
      wr_carry = |prod_step[2*WIDTH-1:WIDTH];
    end else if (alu_wr) begin
      wr_en    = 1'b1;
      wr_hit   = sel_hit;
    end
  end

  // Flags follow every accumulator write and hold otherwise.
  always_comb begin
    carry_next = carry_reg;
    zero_next  = zero_reg;
    neg_next   = neg_reg;
    done_next  = mul_last;
    if (wr_en) begin
      carry_next = wr_carry;
      zero_next  = (wr_data == '0);
      neg_next   = wr_data[WIDTH-1];
    end
  end

  // Flag and done registers.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_reg <= 1'b0;
      zero_reg  <= 1'b0;
      neg_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      carry_reg <= carry_next;
      zero_reg  <= zero_next;
      neg_reg   <= neg_next;
      done_reg  <= done_next;
    end
  end

  assign carry = carry_reg;
  assign zero  = zero_reg;
  assign neg   = neg_reg;
  assign done  = done_reg;

  // Accumulator storage: each entry only updates when it is the write target,
  // so an op on one accumulator can never disturb another.
  for (genvar gi = 0; gi < NUM_ACC; gi++) begin : gen_acc
    logic [WIDTH-1:0] acc_reg;

    // Per-accumulator register with write enable from the shared port.
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n)                    acc_reg <= '0;
      else if (wr_en && wr_hit[gi])  acc_reg <= wr_data;
    end

    assign acc_val[gi] = acc_reg;
  end

endmodule
